// File: rtl/bram_arb_pkg.sv
// Shared widths and types for the BRAM read arbiter and its per-client response FIFOs.
package bram_arb_pkg;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned DEF_NUM_CLIENTS = 4;
  localparam int unsigned DEF_RSP_DEPTH   = 2;
  localparam int unsigned CLIENT_ID_W     = id_width(DEF_NUM_CLIENTS);
  localparam int unsigned CNT_W           = cnt_width(DEF_RSP_DEPTH);

  typedef logic [CLIENT_ID_W-1:0] client_id_t;

endpackage

// File: rtl/bram_arb_rsp_fifo.sv
// Small synchronous response FIFO; head is presented combinationally and reads as 0 when empty.
module bram_arb_rsp_fifo
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_srst,
  input  logic                 i_enq,
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic                 i_deq,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [DATA_SIZE-1:0] o_head
);

  localparam int unsigned PTR_W = id_width(RSP_DEPTH);
  localparam int unsigned CW    = cnt_width(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  logic [DATA_SIZE-1:0] r_mem [RSP_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(RSP_DEPTH));
  assign w_pop   = i_deq & ~o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_enq) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_enq) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      // Push and pop together leave the occupancy unchanged, even when full.
      if (i_enq && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!i_enq && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Round-robin sharing of one 1-cycle-latency BRAM read port among several clients,
// with credit limiting so every returning word always has a FIFO slot waiting for it.
module bram_read_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned ADDR_SIZE   = 9,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned RSP_DEPTH   = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_CLIENTS-1:0]           req_valid,
  input  logic [NUM_CLIENTS*ADDR_SIZE-1:0] req_addr,
  output logic [NUM_CLIENTS-1:0]           req_ready,
  output logic [NUM_CLIENTS-1:0]           rsp_valid,
  output logic [NUM_CLIENTS*DATA_SIZE-1:0] rsp_data,
  input  logic [NUM_CLIENTS-1:0]           rsp_deq,
  output logic                             bram_read_en,
  output logic [ADDR_SIZE-1:0]             bram_read_addr,
  input  logic [DATA_SIZE-1:0]             bram_read_data,
  output logic                             no_pending
);

  localparam int unsigned ID_W = id_width(NUM_CLIENTS);
  localparam int unsigned CW   = cnt_width(RSP_DEPTH);
  localparam logic [CW-1:0]   CREDIT_MAX = CW'(RSP_DEPTH);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_CLIENTS - 1);

  logic [ID_W-1:0]        r_rr;
  logic                   r_pend_valid;
  logic [ID_W-1:0]        r_pend_id;
  logic [CW-1:0]          r_cnt [NUM_CLIENTS];

  logic [NUM_CLIENTS-1:0] w_elig;
  logic [NUM_CLIENTS-1:0] w_grant;
  logic [NUM_CLIENTS-1:0] w_enq;
  logic [NUM_CLIENTS-1:0] w_deq;
  logic [NUM_CLIENTS-1:0] w_full;
  logic [NUM_CLIENTS-1:0] w_empty;
  logic [NUM_CLIENTS-1:0] w_cnt_zero;
  logic                   w_grant_any;
  logic [ID_W-1:0]        w_grant_id;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      // No grants while reset is held, so nothing is launched into a pipeline being flushed.
      assign w_elig[gi]     = req_valid[gi] & (r_cnt[gi] < CREDIT_MAX) & ~RST;
      assign w_enq[gi]      = r_pend_valid & (r_pend_id == ID_W'(gi));
      assign w_deq[gi]      = rsp_deq[gi] & ~w_empty[gi];
      assign w_cnt_zero[gi] = (r_cnt[gi] == '0);
      assign rsp_valid[gi]  = ~w_empty[gi];

      bram_arb_rsp_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .RSP_DEPTH (RSP_DEPTH)
      ) u_rsp_fifo (
        .i_clk   (CLK),
        .i_srst  (RST),
        .i_enq   (w_enq[gi]),
        .i_data  (bram_read_data),
        .i_deq   (w_deq[gi]),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi]),
        .o_head  (rsp_data[gi*DATA_SIZE +: DATA_SIZE])
      );

      a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(w_enq[gi] && w_full[gi] && !w_deq[gi]));
    end
  endgenerate

  always_comb begin : p_rr_scan
    int idx;
    idx         = 0;
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < int'(NUM_CLIENTS); k++) begin
      idx = int'(r_rr) + k;
      if (idx >= int'(NUM_CLIENTS)) begin
        idx = idx - int'(NUM_CLIENTS);
      end
      if (!w_grant_any && w_elig[idx]) begin
        w_grant_any  = 1'b1;
        w_grant[idx] = 1'b1;
        w_grant_id   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    bram_read_addr = '0;
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      if (w_grant[i]) begin
        bram_read_addr = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
      end
    end
  end

  assign req_ready    = w_grant;
  assign bram_read_en = w_grant_any;
  assign no_pending   = ~r_pend_valid & (&w_cnt_zero);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rr         <= '0;
      r_pend_valid <= 1'b0;
      r_pend_id    <= '0;
    end else begin
      r_pend_valid <= w_grant_any;
      r_pend_id    <= w_grant_id;
      if (w_grant_any) begin
        r_rr <= (w_grant_id == LAST_ID) ? '0 : w_grant_id + 1'b1;
      end
    end
  end

  // Credits count words accepted but not yet popped, whether still in flight or buffered.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      if (RST) begin
        r_cnt[i] <= '0;
      end else if (w_grant[i] && !w_deq[i]) begin
        r_cnt[i] <= r_cnt[i] + CW'(1);
      end else if (!w_grant[i] && w_deq[i]) begin
        r_cnt[i] <= r_cnt[i] - CW'(1);
      end
    end
  end

endmodule
